// File: rtl/ring_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : ring_arbiter_if
// Purpose : Request/grant bundle between requesting engines and ring_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
interface ring_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] REQ;
  logic         DONE;
  logic [N-1:0] GRANT;
  logic         VALID;
  logic [N-1:0] TOKEN;
  logic         EXPIRED;

  modport master (
    output REQ, DONE,
    input  GRANT, VALID, TOKEN, EXPIRED
  );

  modport slave (
    input  REQ, DONE,
    output GRANT, VALID, TOKEN, EXPIRED
  );
endinterface
`default_nettype wire

// File: rtl/ring_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ring_arbiter
// Purpose : Token-ring round-robin arbiter with completion/withdraw/timeout release.
// Rev     : 1.0  initial release
// ============================================================================
module ring_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8
) (
  input  wire logic     CLK,
  input  wire logic     RESET,
  ring_arbiter_if.slave bus
);

  localparam int              C_CW        = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [C_CW-1:0] C_HOLD_LAST = C_CW'(HOLD_MAX - 1);
  localparam logic [N-1:0]    C_ONE       = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [N-1:0]    token_q, token_d;
  logic            valid_q, valid_d;
  logic            expired_q, expired_d;
  logic [C_CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]    w_upper;
  logic [N-1:0]    w_upper_first;
  logic [N-1:0]    w_any_first;
  logic [N-1:0]    w_pick;
  logic            w_req_g;
  logic            w_timeout;

  // Requests at or above the token index win; otherwise wrap to the lowest request.
  assign w_upper       = bus.REQ & ~(token_q - C_ONE);
  assign w_upper_first = w_upper & (~w_upper + C_ONE);
  assign w_any_first   = bus.REQ & (~bus.REQ + C_ONE);
  assign w_pick        = (|w_upper) ? w_upper_first : w_any_first;

  assign w_req_g   = |(bus.REQ & grant_q);
  assign w_timeout = (cnt_q == C_HOLD_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      token_q   <= C_ONE;
      valid_q   <= 1'b0;
      expired_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      token_q   <= token_d;
      valid_q   <= valid_d;
      expired_q <= expired_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    token_d   = token_q;
    expired_d = expired_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        expired_d = 1'b0;
        if (|bus.REQ) begin
          grant_d = w_pick;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.DONE || !w_req_g || w_timeout) begin
          grant_d   = '0;
          token_d   = {grant_q[N-2:0], grant_q[N-1]};
          // A completion or withdrawal in the same cycle outranks the timeout.
          expired_d = w_timeout && !bus.DONE && w_req_g;
          state_d   = S_GAP;
        end else begin
          cnt_d = w_timeout ? cnt_q : cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        expired_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        grant_d   = '0;
        expired_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
    valid_d = |grant_d;
  end

  assign bus.GRANT   = grant_q;
  assign bus.VALID   = valid_q;
  assign bus.TOKEN   = token_q;
  assign bus.EXPIRED = expired_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ring_arbiter
// Purpose : Scoreboard-driven bench for ring_arbiter (N=4, HOLD_MAX=8).
// Rev     : 1.0  initial release
// ============================================================================
module tb_ring_arbiter;
  localparam int N        = 4;
  localparam int HOLD_MAX = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ring_arbiter_if #(.N(N)) bus();

  ring_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] grant;
    logic [N-1:0] token;
    logic         expired;
  } step_t;

  step_t sb[$];
  int    n_pass  = 0;
  int    n_total = 0;

  // Each entry: inputs applied during a cycle and the outputs expected in that same cycle.
  function automatic void push(input logic [N-1:0] req, input logic done,
                               input logic [N-1:0] grant, input logic [N-1:0] token,
                               input logic expired);
    step_t s;
    s.req = req; s.done = done; s.grant = grant; s.token = token; s.expired = expired;
    sb.push_back(s);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.REQ = '0;
    bus.DONE = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    step_t s;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) push(4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b0);
    for (int c = 0; sb.size() > 0; c++) begin
      s = sb.pop_front();
      bus.REQ = s.req; bus.DONE = s.done;
      @(posedge clk); #1;
      n_total++;
      if ({bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED} !== {s.grant, |s.grant, s.token, s.expired})
        $display("FAIL reset c%0d: got g=%b v=%b t=%b e=%b want g=%b v=%b t=%b e=%b", c,
                 bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED, s.grant, |s.grant, s.token, s.expired);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    step_t s;
    do_reset();
    push(4'b0100, 1'b0, 4'b0000, 4'b0001, 1'b0);
    push(4'b0100, 1'b0, 4'b0100, 4'b0001, 1'b0);
    push(4'b0100, 1'b0, 4'b0100, 4'b0001, 1'b0);
    push(4'b0100, 1'b1, 4'b0100, 4'b0001, 1'b0);
    push(4'b0100, 1'b0, 4'b0000, 4'b1000, 1'b0);
    push(4'b0100, 1'b0, 4'b0000, 4'b1000, 1'b0);
    push(4'b0100, 1'b1, 4'b0100, 4'b1000, 1'b0);
    push(4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b0);
    push(4'b0000, 1'b0, 4'b0000, 4'b1000, 1'b0);
    for (int c = 0; sb.size() > 0; c++) begin
      s = sb.pop_front();
      bus.REQ = s.req; bus.DONE = s.done;
      n_total++;
      if ({bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED} !== {s.grant, |s.grant, s.token, s.expired})
        $display("FAIL single c%0d: got g=%b v=%b t=%b e=%b want g=%b v=%b t=%b e=%b", c,
                 bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED, s.grant, |s.grant, s.token, s.expired);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rotation();
    step_t s;
    logic [N-1:0] g_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] t_seq [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    do_reset();
    push(4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b0);
    for (int k = 0; k < 5; k++) begin
      push(4'b1111, 1'b1, g_seq[k], (k == 0) ? 4'b0001 : t_seq[k-1], 1'b0);
      push(4'b1111, 1'b0, 4'b0000, t_seq[k], 1'b0);
      push(4'b1111, 1'b0, 4'b0000, t_seq[k], 1'b0);
    end
    for (int c = 0; sb.size() > 0; c++) begin
      s = sb.pop_front();
      bus.REQ = s.req; bus.DONE = s.done;
      n_total++;
      if ({bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED} !== {s.grant, |s.grant, s.token, s.expired})
        $display("FAIL rotation c%0d: got g=%b v=%b t=%b e=%b want g=%b v=%b t=%b e=%b", c,
                 bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED, s.grant, |s.grant, s.token, s.expired);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    step_t s;
    do_reset();
    push(4'b0010, 1'b0, 4'b0000, 4'b0001, 1'b0);
    for (int k = 0; k < HOLD_MAX; k++) push(4'b0010, 1'b0, 4'b0010, 4'b0001, 1'b0);
    push(4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b1);
    push(4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0);
    push(4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0);
    for (int c = 0; sb.size() > 0; c++) begin
      s = sb.pop_front();
      bus.REQ = s.req; bus.DONE = s.done;
      n_total++;
      if ({bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED} !== {s.grant, |s.grant, s.token, s.expired})
        $display("FAIL timeout c%0d: got g=%b v=%b t=%b e=%b want g=%b v=%b t=%b e=%b", c,
                 bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED, s.grant, |s.grant, s.token, s.expired);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_withdraw_precedence();
    step_t s;
    do_reset();
    push(4'b1000, 1'b0, 4'b0000, 4'b0001, 1'b0);
    push(4'b1000, 1'b0, 4'b1000, 4'b0001, 1'b0);
    push(4'b0000, 1'b0, 4'b1000, 4'b0001, 1'b0);
    push(4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b0);
    push(4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b0);
    for (int c = 0; sb.size() > 0; c++) begin
      s = sb.pop_front();
      bus.REQ = s.req; bus.DONE = s.done;
      n_total++;
      if ({bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED} !== {s.grant, |s.grant, s.token, s.expired})
        $display("FAIL withdraw c%0d: got g=%b v=%b t=%b e=%b want g=%b v=%b t=%b e=%b", c,
                 bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED, s.grant, |s.grant, s.token, s.expired);
      else n_pass++;
      @(posedge clk); #1;
    end
    do_reset();
    push(4'b0001, 1'b0, 4'b0000, 4'b0001, 1'b0);
    for (int k = 1; k < HOLD_MAX; k++) push(4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b0);
    push(4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b0);
    push(4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b0);
    push(4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b0);
    for (int c = 0; sb.size() > 0; c++) begin
      s = sb.pop_front();
      bus.REQ = s.req; bus.DONE = s.done;
      n_total++;
      if ({bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED} !== {s.grant, |s.grant, s.token, s.expired})
        $display("FAIL done_vs_timeout c%0d: got g=%b v=%b t=%b e=%b want g=%b v=%b t=%b e=%b", c,
                 bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED, s.grant, |s.grant, s.token, s.expired);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    step_t s;
    do_reset();
    push(4'b0001, 1'b0, 4'b0000, 4'b0001, 1'b0);
    push(4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b0);
    push(4'b0100, 1'b0, 4'b0000, 4'b0010, 1'b0);
    push(4'b0100, 1'b0, 4'b0000, 4'b0010, 1'b0);
    push(4'b0100, 1'b0, 4'b0100, 4'b0010, 1'b0);
    push(4'b0100, 1'b0, 4'b0000, 4'b0001, 1'b0);
    push(4'b1010, 1'b0, 4'b0010, 4'b0001, 1'b0);
    for (int c = 0; sb.size() > 2; c++) begin
      s = sb.pop_front();
      bus.REQ = s.req; bus.DONE = s.done;
      n_total++;
      if ({bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED} !== {s.grant, |s.grant, s.token, s.expired})
        $display("FAIL async_pre c%0d: got g=%b v=%b t=%b e=%b want g=%b v=%b t=%b e=%b", c,
                 bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED, s.grant, |s.grant, s.token, s.expired);
      else n_pass++;
      @(posedge clk); #1;
    end
    // Still inside the grant-0100 cycle: reset lands between edges.
    #2 rst = 1'b1;
    #1;
    s = sb.pop_front();
    n_total++;
    if ({bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED} !== {s.grant, |s.grant, s.token, s.expired})
      $display("FAIL async_mid: got g=%b v=%b t=%b e=%b want g=%b v=%b t=%b e=%b",
               bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED, s.grant, |s.grant, s.token, s.expired);
    else n_pass++;
    #2 rst = 1'b0;
    s = sb.pop_front();
    bus.REQ = s.req; bus.DONE = s.done;
    @(posedge clk); #1;
    n_total++;
    if ({bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED} !== {s.grant, |s.grant, s.token, s.expired})
      $display("FAIL async_after: got g=%b v=%b t=%b e=%b want g=%b v=%b t=%b e=%b",
               bus.GRANT, bus.VALID, bus.TOKEN, bus.EXPIRED, s.grant, |s.grant, s.token, s.expired);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.REQ  = '0;
    bus.DONE = 1'b0;
    #1;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_withdraw_precedence();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
